// File: rtl/wb_store_buffer_ctrl.sv
// Store buffer between WB commit and the dcache write port: circular FIFO of committed
// stores, in-order drain over a req/addr_ok/data_ok handshake, and a load-alias flag.
module wb_store_buffer_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_ce_i,
  input  logic [AW-1:0]   commit_addr_i,
  input  logic [DW-1:0]   commit_data_i,
  input  logic [DW/8-1:0] commit_wstrb_i,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o,
  input  logic [AW-1:0]   ld_addr_i,
  output logic            ld_hit_o,
  output logic            cache_req_o,
  output logic [AW-1:0]   cache_addr_o,
  output logic [DW-1:0]   cache_wdata_o,
  output logic [DW/8-1:0] cache_wstrb_o,
  input  logic            cache_addr_ok_i,
  input  logic            cache_data_ok_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [DEPTH-1:0] valid;
  logic             push;
  logic             pop;
  logic             full;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [SW-1:0] strb_q [DEPTH];

  // Byte offset never takes part in the alias compare.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_addr_i[1:0];

  // FIFO occupancy and handshake decode
  always_comb begin
    full = (count == CW'(DEPTH));
    pop  = ((state == S_REQ) && cache_addr_ok_i && cache_data_ok_i) ||
           ((state == S_WAIT) && cache_data_ok_i);
    push = commit_ce_i && (!full || pop);
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain FSM next state; a same-cycle push counts so IDLE requests one cycle after commit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (count_nxt != '0) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (cache_addr_ok_i) begin
          if (!cache_data_ok_i)       state_nxt = S_WAIT;
          else if (count_nxt != '0)   state_nxt = S_REQ;
          else                        state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cache_data_ok_i) begin
          state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pointers, valid bits and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      valid       <= '0;
      overflow_o  <= 1'b0;
      empty_o     <= 1'b1;
      full_o      <= 1'b0;
      cache_req_o <= 1'b0;
    end else begin
      count       <= count_nxt;
      empty_o     <= (count_nxt == '0);
      full_o      <= (count_nxt == CW'(DEPTH));
      cache_req_o <= (state_nxt == S_REQ);
      if (commit_ce_i && !push) overflow_o <= 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      // When full the push reuses the slot being popped, so set wins over clear.
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        valid[wr_ptr] <= 1'b1;
      end
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= commit_addr_i;
      data_q[wr_ptr] <= commit_data_i;
      strb_q[wr_ptr] <= commit_wstrb_i;
    end
  end

  assign cache_addr_o  = addr_q[rd_ptr];
  assign cache_wdata_o = data_q[rd_ptr];
  assign cache_wstrb_o = strb_q[rd_ptr];

  // Word-granular alias check over every valid entry, in-flight head included
  always_comb begin
    ld_hit_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (addr_q[i][AW-1:2] == ld_addr_i[AW-1:2])) ld_hit_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_store_buffer_ctrl.sv
// Bench for wb_store_buffer_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based store buffer model.
module tb_wb_store_buffer_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] caddr;
  logic [31:0] cdata;
  logic [3:0]  cstrb;
  logic        full_o, empty_o, overflow_o;
  logic [31:0] ld;
  logic        ld_hit_o;
  logic        req;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic [3:0]  rstrb;
  logic        aok, dok;

  int total = 0;
  int bad   = 0;

  wb_store_buffer_ctrl #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .commit_ce_i(ce), .commit_addr_i(caddr), .commit_data_i(cdata), .commit_wstrb_i(cstrb),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .ld_addr_i(ld), .ld_hit_o(ld_hit_o),
    .cache_req_o(req), .cache_addr_o(raddr), .cache_wdata_o(rdata), .cache_wstrb_o(rstrb),
    .cache_addr_ok_i(aok), .cache_data_ok_i(dok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  // Model: pending stores in order, plus whether the head is being requested or awaited.
  ent_t mq[$];
  bit   m_req = 1'b0;
  bit   m_out = 1'b0;
  bit   m_ovf = 1'b0;
  bit   m_ok  = 1'b0;
  bit   e_pop, e_push;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_hit(logic [31:0] la);
    foreach (mq[i]) if (mq[i].a[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_req = 1'b0;
      m_out = 1'b0;
      m_ovf = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      e_pop  = (m_req && aok && dok) || (m_out && dok);
      e_push = ce && ((mq.size() < int'(DEPTH)) || e_pop);
      if (ce && !e_push) m_ovf = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_push) mq.push_back('{caddr, cdata, cstrb});
      if (m_req && aok && !dok) begin
        m_req = 1'b0;
        m_out = 1'b1;
      end else if (e_pop) begin
        m_out = 1'b0;
        m_req = (mq.size() != 0);
      end else if (!m_req && !m_out) begin
        m_req = (mq.size() != 0);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("req", 32'(req), 32'(m_req));
      if (m_req && mq.size() != 0) begin
        chk("cache_addr", raddr, mq[0].a);
        chk("cache_wdata", rdata, mq[0].d);
        chk("cache_wstrb", 32'(rstrb), 32'(mq[0].s));
      end
      chk("empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("full", 32'(full_o), 32'(mq.size() == int'(DEPTH)));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("ld_hit", 32'(ld_hit_o), 32'(m_hit(ld)));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    ce  = 1'b0;
    aok = 1'b0;
    dok = 1'b0;
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce    = 1'b1;
    caddr = a;
    cdata = d;
    cstrb = s;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; aok = 1'b0; dok = 1'b0;
    caddr = '0; cdata = '0; cstrb = '0; ld = 32'hFFFF_FFF0;
    nxt();
    nxt();
    rst = 1'b0;
    peek();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_hit", 32'(ld_hit_o), 32'd0);

    // single store: t0 commit, t1 req+addr_ok, t2 wait, t3 data_ok, t4 empty
    commit(32'h1000, 32'hDEAD_BEEF, 4'hF);
    nxt();
    peek();
    chk("single_req", 32'(req), 32'd1);
    chk("single_addr", raddr, 32'h1000);
    chk("single_data", rdata, 32'hDEAD_BEEF);
    chk("single_strb", 32'(rstrb), 32'hF);
    aok = 1'b1;
    nxt();
    peek();
    chk("single_wait_req", 32'(req), 32'd0);
    nxt();
    dok = 1'b1;
    peek();
    chk("single_not_empty", 32'(empty_o), 32'd0);
    nxt();
    peek();
    chk("single_empty", 32'(empty_o), 32'd1);

    // full with simultaneous pop and push: no overflow, new entry drained last
    for (int i = 0; i < 4; i++) begin
      commit(32'h100 + 32'(4 * i), $urandom, 4'hF);
      nxt();
    end
    peek();
    chk("fp_full", 32'(full_o), 32'd1);
    chk("fp_head", raddr, 32'h100);
    aok = 1'b1;
    nxt();
    dok = 1'b1;
    commit(32'h110, 32'hCAFE_0110, 4'h3);
    nxt();
    peek();
    chk("fp_still_full", 32'(full_o), 32'd1);
    chk("fp_no_ovf", 32'(overflow_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      peek();
      chk("fp_drain_req", 32'(req), 32'd1);
      chk("fp_drain_addr", raddr, 32'h104 + 32'(4 * k));
      aok = 1'b1;
      dok = 1'b1;
      nxt();
    end
    peek();
    chk("fp_empty", 32'(empty_o), 32'd1);

    // fill, overflow on 5th commit, drain order 0,4,8,C via combined handshake
    for (int i = 0; i < 4; i++) begin
      commit(32'(4 * i), $urandom, 4'($urandom));
      nxt();
    end
    peek();
    chk("fill_full", 32'(full_o), 32'd1);
    commit(32'h40, 32'h5555_5555, 4'hF);
    nxt();
    peek();
    chk("fill_ovf", 32'(overflow_o), 32'd1);
    chk("fill_count4", 32'(full_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      peek();
      chk("fill_drain_req", 32'(req), 32'd1);
      chk("fill_drain_addr", raddr, 32'(4 * k));
      aok = 1'b1;
      dok = 1'b1;
      nxt();
    end
    peek();
    chk("fill_empty", 32'(empty_o), 32'd1);
    chk("fill_ovf_sticky", 32'(overflow_o), 32'd1);

    // alias check
    commit(32'h2004, 32'h1234_5678, 4'hF);
    nxt();
    ld = 32'h2006;
    peek();
    chk("alias_hit", 32'(ld_hit_o), 32'd1);
    ld = 32'h2008;
    peek();
    chk("alias_miss", 32'(ld_hit_o), 32'd0);
    ld = 32'h2006;
    aok = 1'b1;
    nxt();
    peek();
    chk("alias_inflight", 32'(ld_hit_o), 32'd1);
    dok = 1'b1;
    peek();
    chk("alias_pop_cycle", 32'(ld_hit_o), 32'd1);
    nxt();
    peek();
    chk("alias_after_pop", 32'(ld_hit_o), 32'd0);
    ld = 32'h3000;
    commit(32'h3000, 32'h0, 4'h1);
    peek();
    chk("alias_push_hidden", 32'(ld_hit_o), 32'd0);
    nxt();
    peek();
    chk("alias_push_visible", 32'(ld_hit_o), 32'd1);
    aok = 1'b1;
    dok = 1'b1;
    nxt();
    peek();
    chk("alias_drained", 32'(empty_o), 32'd1);

    // reset while waiting on data_ok with 3 entries
    ld = 32'h500;
    for (int i = 0; i < 3; i++) begin
      commit(32'h500 + 32'(4 * i), $urandom, 4'hF);
      nxt();
    end
    aok = 1'b1;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    peek();
    chk("rstw_req", 32'(req), 32'd0);
    chk("rstw_empty", 32'(empty_o), 32'd1);
    chk("rstw_ovf", 32'(overflow_o), 32'd0);
    chk("rstw_hit", 32'(ld_hit_o), 32'd0);

    // randomized traffic over a small address window so aliases and fills are frequent
    for (int n = 0; n < 3000; n++) begin
      ce    = 1'($urandom_range(0, 1));
      caddr = 32'h4000 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      cdata = $urandom;
      cstrb = 4'($urandom);
      aok   = ($urandom_range(0, 2) != 0);
      dok   = ($urandom_range(0, 2) == 0);
      ld    = 32'h4000 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 249) == 0);
      nxt();
    end
    rst = 1'b0;
    nxt();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
